// File: rtl/servo_track_counter_if.sv
// Signal bundle between the servo tracking loop controller and the tracking counter.
// The controller (master) drives the step enable, comparator decision and parallel load.
// The counter (slave) returns the DAC code, the rail flags, the lock flag and the
// captured conversion result with its valid pulse.
interface servo_track_counter_if #(
    parameter int WIDTH = 4
);
    logic             En;          // step enable
    logic             UpOrDown;    // comparator decision, 1 = up
    logic             Load;        // synchronous parallel load
    logic [WIDTH-1:0] LoadValue;   // value taken by Load
    logic [WIDTH-1:0] Count;       // current DAC code
    logic             AtMax;       // Count at top rail
    logic             AtMin;       // Count at bottom rail
    logic             Locked;      // loop dithering around the input
    logic [WIDTH-1:0] Sample;      // captured conversion result
    logic             SampleValid; // one-cycle pulse when Sample updates

    modport master (
        output En, UpOrDown, Load, LoadValue,
        input  Count, AtMax, AtMin, Locked, Sample, SampleValid
    );

    modport slave (
        input  En, UpOrDown, Load, LoadValue,
        output Count, AtMax, AtMin, Locked, Sample, SampleValid
    );
endinterface

// File: rtl/servo_track_counter.sv
// Up/down tracking counter for a servo-tracking ADC loop.
// Each enabled clock moves the DAC code one LSB toward the comparator decision,
// either saturating or wrapping at the rails. Consecutive direction reversals are
// counted; LOCK_CYCLES of them in a row mark the loop as locked, and the rising
// edge of lock captures the current code as the conversion result.
// Ports:
//   Clk   - single clock, rising edge
//   Reset - synchronous, active-high
//   bus   - slave side of servo_track_counter_if (En, UpOrDown, Load, LoadValue in;
//           Count, AtMax, AtMin, Locked, Sample, SampleValid out)
module servo_track_counter #(
    parameter int WIDTH       = 4,
    parameter int SATURATE    = 1,
    parameter int LOCK_CYCLES = 3,
    parameter int RESET_VALUE = 0
) (
    input  logic                  Clk,
    input  logic                  Reset,
    servo_track_counter_if.slave  bus
);
    localparam int               RCW      = $clog2(LOCK_CYCLES + 1);
    localparam logic [WIDTH-1:0] MAXV     = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] RST_CODE = WIDTH'(RESET_VALUE);
    localparam logic [RCW-1:0]   LOCK_N   = RCW'(LOCK_CYCLES);

    logic [WIDTH-1:0] count_p0;
    logic [RCW-1:0]   revcnt_p0;
    logic             haveprev_p0;
    logic             prevdir_p0;
    logic             locked_p0;
    logic [WIDTH-1:0] sample_p0;
    logic             vld_p0;

    logic [WIDTH-1:0] count_step;
    logic [RCW-1:0]   revcnt_step;
    logic             locked_step;
    logic             capture;

    // One LSB move with the rail behaviour applied after the modulo arithmetic.
    function automatic logic [WIDTH-1:0] step_code(input logic [WIDTH-1:0] c,
                                                    input logic up);
        logic [WIDTH-1:0] r;
        if (up) begin
            r = c + 1'b1;
            if (c == MAXV && SATURATE != 0) r = MAXV;
        end else begin
            r = c - 1'b1;
            if (c == '0 && SATURATE != 0) r = '0;
        end
        return r;
    endfunction

    // Reversal count saturates at the lock threshold so continued dither stays locked.
    function automatic logic [RCW-1:0] next_revcnt(input logic [RCW-1:0] rc,
                                                    input logic reversal);
        logic [RCW-1:0] r;
        r = '0;
        if (reversal) r = (rc == LOCK_N) ? LOCK_N : rc + 1'b1;
        return r;
    endfunction

    always_comb begin
        count_step  = step_code(count_p0, bus.UpOrDown);
        // A held step at a rail still counts as a step in its direction.
        revcnt_step = next_revcnt(revcnt_p0, haveprev_p0 && (bus.UpOrDown != prevdir_p0));
        locked_step = (revcnt_step == LOCK_N);
        capture     = locked_step && !locked_p0;
    end

    // Stage p0: counter, dither tracking and capture registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            count_p0    <= RST_CODE;
            revcnt_p0   <= '0;
            haveprev_p0 <= 1'b0;
            prevdir_p0  <= 1'b0;
            locked_p0   <= 1'b0;
            sample_p0   <= '0;
            vld_p0      <= 1'b0;
        end else if (bus.Load) begin
            count_p0    <= bus.LoadValue;
            revcnt_p0   <= '0;
            haveprev_p0 <= 1'b0;
            locked_p0   <= 1'b0;
            vld_p0      <= 1'b0;
        end else if (bus.En) begin
            count_p0    <= count_step;
            revcnt_p0   <= revcnt_step;
            haveprev_p0 <= 1'b1;
            prevdir_p0  <= bus.UpOrDown;
            locked_p0   <= locked_step;
            vld_p0      <= capture;
            if (capture) sample_p0 <= count_step;
        end else begin
            vld_p0      <= 1'b0;
        end
    end

    assign bus.Count       = count_p0;
    assign bus.AtMax       = (count_p0 == MAXV);
    assign bus.AtMin       = (count_p0 == '0);
    assign bus.Locked      = locked_p0;
    assign bus.Sample      = sample_p0;
    assign bus.SampleValid = vld_p0;
endmodule

// File: tb/tb_servo_track_counter.sv
// Bench for servo_track_counter: two instances (saturating and wrapping) receive the
// same directed stimulus; a behavioural model tracks both and is compared every cycle,
// with hand-computed literal expectations at the key points.
module tb_servo_track_counter;
    logic Clk = 1'b0;
    logic Reset;
    int   total = 0;
    int   bad   = 0;
    bit   chk_en = 1'b0;

    always #5 Clk = ~Clk;

    servo_track_counter_if #(.WIDTH(4)) bus0 ();
    servo_track_counter_if #(.WIDTH(4)) bus1 ();

    servo_track_counter #(.WIDTH(4), .SATURATE(0), .LOCK_CYCLES(3), .RESET_VALUE(0))
        dut0 (.Clk(Clk), .Reset(Reset), .bus(bus0));
    servo_track_counter #(.WIDTH(4), .SATURATE(1), .LOCK_CYCLES(3), .RESET_VALUE(0))
        dut1 (.Clk(Clk), .Reset(Reset), .bus(bus1));

    // Model state, index 0 = wrapping instance, 1 = saturating instance
    int m_cnt[2], m_rev[2], m_have[2], m_dir[2], m_lk[2], m_smp[2], m_sv[2];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input bit rst, input bit ld, input int lv,
                              input bit en, input bit ud);
        for (int s = 0; s < 2; s++) begin
            if (rst) begin
                m_cnt[s] = 0; m_rev[s] = 0; m_have[s] = 0; m_dir[s] = 0;
                m_lk[s] = 0; m_smp[s] = 0; m_sv[s] = 0;
            end else if (ld) begin
                m_cnt[s] = lv; m_rev[s] = 0; m_have[s] = 0; m_lk[s] = 0; m_sv[s] = 0;
            end else if (en) begin
                int nv;
                int nl;
                nv = ud ? m_cnt[s] + 1 : m_cnt[s] - 1;
                if (nv > 15) nv = (s == 1) ? 15 : 0;
                if (nv < 0)  nv = (s == 1) ? 0 : 15;
                if (m_have[s] != 0 && int'(ud) != m_dir[s])
                    m_rev[s] = (m_rev[s] + 1 > 3) ? 3 : m_rev[s] + 1;
                else
                    m_rev[s] = 0;
                m_dir[s]  = ud;
                m_have[s] = 1;
                nl = (m_rev[s] == 3) ? 1 : 0;
                m_sv[s] = (nl == 1 && m_lk[s] == 0) ? 1 : 0;
                if (m_sv[s] == 1) m_smp[s] = nv;
                m_lk[s]  = nl;
                m_cnt[s] = nv;
            end else begin
                m_sv[s] = 0;
            end
        end
    endtask

    // Apply one clock edge with the given inputs; returns after the outputs are compared.
    task automatic cyc(input bit rst, input bit ld, input int lv, input bit en, input bit ud);
        Reset = rst;
        bus0.Load = ld; bus1.Load = ld;
        bus0.LoadValue = 4'(lv); bus1.LoadValue = 4'(lv);
        bus0.En = en; bus1.En = en;
        bus0.UpOrDown = ud; bus1.UpOrDown = ud;
        @(posedge Clk);
        model_edge(rst, ld, lv, en, ud);
        chk_en = 1'b1;
        @(negedge Clk);
        #1;
    endtask

    always @(negedge Clk) begin
        if (chk_en) begin
            check("w_count",  bus0.Count,       m_cnt[0]);
            check("w_atmax",  bus0.AtMax,       (m_cnt[0] == 15) ? 1 : 0);
            check("w_atmin",  bus0.AtMin,       (m_cnt[0] == 0) ? 1 : 0);
            check("w_locked", bus0.Locked,      m_lk[0]);
            check("w_sample", bus0.Sample,      m_smp[0]);
            check("w_valid",  bus0.SampleValid, m_sv[0]);
            check("s_count",  bus1.Count,       m_cnt[1]);
            check("s_atmax",  bus1.AtMax,       (m_cnt[1] == 15) ? 1 : 0);
            check("s_atmin",  bus1.AtMin,       (m_cnt[1] == 0) ? 1 : 0);
            check("s_locked", bus1.Locked,      m_lk[1]);
            check("s_sample", bus1.Sample,      m_smp[1]);
            check("s_valid",  bus1.SampleValid, m_sv[1]);
        end
    end

    initial begin
        int up_seq[4];
        int exp_cnt[4];
        Reset = 1'b1;
        bus0.En = 0; bus1.En = 0; bus0.Load = 0; bus1.Load = 0;
        bus0.UpOrDown = 0; bus1.UpOrDown = 0; bus0.LoadValue = 0; bus1.LoadValue = 0;

        // Reset state
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        check("rst_count", bus1.Count, 0);
        check("rst_atmin", bus1.AtMin, 1);
        check("rst_locked", bus1.Locked, 0);
        check("rst_sample", bus1.Sample, 0);
        check("rst_valid", bus1.SampleValid, 0);

        // 20 up-steps, saturating instance climbs then holds at 15
        for (int i = 1; i <= 20; i++) begin
            cyc(0, 0, 0, 1, 1);
            if (i == 14) check("sat_step14_atmax", bus1.AtMax, 0);
            if (i == 15) begin
                check("sat_step15_count", bus1.Count, 15);
                check("sat_step15_atmax", bus1.AtMax, 1);
            end
            if (i == 16) check("wrap_step16_count", bus0.Count, 0);
        end
        check("sat_hold_count", bus1.Count, 15);
        check("sat_hold_locked", bus1.Locked, 0);

        // Wrapping at both rails: load 14, up x3, down x3
        cyc(0, 1, 14, 0, 0);
        exp_cnt[0] = 15; exp_cnt[1] = 0; exp_cnt[2] = 1;
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 1, 1);
            check("wrap_up", bus0.Count, exp_cnt[i]);
        end
        exp_cnt[0] = 0; exp_cnt[1] = 15; exp_cnt[2] = 14;
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 1, 0);
            check("wrap_down", bus0.Count, exp_cnt[i]);
        end
        check("sat_rail_count", bus1.Count, 12);

        // Dither to lock: load 5 then 1,0,1,0
        cyc(0, 1, 5, 0, 0);
        up_seq[0] = 1; up_seq[1] = 0; up_seq[2] = 1; up_seq[3] = 0;
        exp_cnt[0] = 6; exp_cnt[1] = 5; exp_cnt[2] = 6; exp_cnt[3] = 5;
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 1, up_seq[i][0]);
            check("dither_count", bus1.Count, exp_cnt[i]);
            if (i < 3) check("dither_prelock", bus1.Locked, 0);
        end
        check("lock1_locked", bus1.Locked, 1);
        check("lock1_valid", bus1.SampleValid, 1);
        check("lock1_sample", bus1.Sample, 5);
        cyc(0, 0, 0, 1, 1);
        check("lock1_cont_count", bus1.Count, 6);
        check("lock1_cont_locked", bus1.Locked, 1);
        check("lock1_cont_valid", bus1.SampleValid, 0);
        check("lock1_cont_sample", bus1.Sample, 5);

        // Same-direction step drops lock, then re-lock on down,up,down
        cyc(0, 0, 0, 1, 1);
        check("unlock_locked", bus1.Locked, 0);
        check("unlock_count", bus1.Count, 7);
        cyc(0, 0, 0, 1, 1);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 1);
        check("relock_pre", bus1.Locked, 0);
        cyc(0, 0, 0, 1, 0);
        check("relock_locked", bus1.Locked, 1);
        check("relock_valid", bus1.SampleValid, 1);
        check("relock_sample", bus1.Sample, 7);

        // En=0 mid-dither holds everything, dither count resumes afterwards
        cyc(0, 1, 10, 1, 1);
        check("load_no_step", bus1.Count, 10);
        cyc(0, 0, 0, 1, 1);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 1);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 0, i[0]);
            check("hold_count", bus1.Count, 11);
            check("hold_locked", bus1.Locked, 0);
        end
        cyc(0, 0, 0, 1, 0);
        check("resume_locked", bus1.Locked, 1);
        check("resume_sample", bus1.Sample, 10);
        check("resume_valid", bus1.SampleValid, 1);
        cyc(0, 0, 0, 0, 1);
        check("resume_pulse_end", bus1.SampleValid, 0);

        // Reset wins over load and a locking step
        cyc(0, 1, 3, 0, 0);
        cyc(0, 0, 0, 1, 1);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 1);
        cyc(1, 1, 9, 1, 0);
        check("rst_pri_count", bus1.Count, 0);
        check("rst_pri_locked", bus1.Locked, 0);
        check("rst_pri_sample", bus1.Sample, 0);
        check("rst_pri_valid", bus1.SampleValid, 0);
        cyc(0, 0, 0, 0, 0);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
